// File: rtl/mm_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mm_pkg
// Description : Shared constants, state type and result byte-position helper
//               for the matrix_mult sequencer (mm_seq_ctrl).
//               MM_ELEMS      - elements per 3x3 matrix
//               MM_LOAD_BYTES - operand bytes per frame (A then B)
//               MM_OUT_BYTES  - result bytes per frame (3 bytes per C entry)
// Revision    : 1.0 - initial release
// ============================================================================
package mm_pkg;

  localparam int MM_ELEMS         = 9;
  localparam int MM_LOAD_BYTES    = 18;
  localparam int MM_OUT_BYTES     = 27;
  localparam int MM_BYTES_PER_RES = 3;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } mm_seq_state_t;

  // Position of output byte k inside the C array: which element, which byte.
  typedef struct packed {
    logic [3:0] elem;
    logic [1:0] sel;
  } mm_byte_pos_t;

  function automatic mm_byte_pos_t mm_res_byte_pos(input logic [4:0] k);
    mm_byte_pos_t p;
    p.elem = 4'(k / 5'(MM_BYTES_PER_RES));
    p.sel  = 2'(k % 5'(MM_BYTES_PER_RES));
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mm_result_serializer.sv
`default_nettype none
// ============================================================================
// Module      : mm_result_serializer
// Description : Holds the captured C matrix and streams it out as 27 bytes,
//               3 little-endian bytes per element, elements in index order.
//               Bits above RES_W read as zero.
// Ports       : clk, reset (async, active-low)
//               capture    - load C regs (or zeros when zero_fill) and start
//               zero_fill  - capture zeros instead of c_in
//               c_in       - engine results, element i at [i*RES_W +: RES_W]
//               out_ready  - sink accepts out_data
//               out_valid / out_data / out_last - result byte stream
//               frame_done - handshake on the final byte of the frame
// Revision    : 1.0 - initial release
// ============================================================================
module mm_result_serializer
  import mm_pkg::*;
#(
  parameter int RES_W = 18
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      capture,
  input  logic                      zero_fill,
  input  logic [MM_ELEMS*RES_W-1:0] c_in,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [7:0]                out_data,
  output logic                      out_last,
  output logic                      frame_done
);

  localparam logic [4:0] c_LAST_IDX = 5'(MM_OUT_BYTES - 1);

  logic [MM_ELEMS*RES_W-1:0] r_c;
  logic [4:0]                r_idx;
  logic                      r_valid;

  mm_byte_pos_t              w_pos;
  logic [RES_W-1:0]          w_elem;
  logic [23:0]               w_wide;
  logic                      w_fire;

  assign w_fire     = r_valid & out_ready;
  assign frame_done = w_fire & (r_idx == c_LAST_IDX);
  assign out_valid  = r_valid;
  assign out_last   = r_valid & (r_idx == c_LAST_IDX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_c     <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
    end else if (capture) begin
      r_c     <= zero_fill ? '0 : c_in;
      r_idx   <= '0;
      r_valid <= 1'b1;
    end else if (w_fire) begin
      if (r_idx == c_LAST_IDX) begin
        r_idx   <= '0;
        r_valid <= 1'b0;
      end else begin
        r_idx   <= r_idx + 5'd1;
      end
    end
  end

  // Byte mux; index only moves on a handshake so data holds during stalls.
  always_comb begin
    w_pos  = mm_res_byte_pos(r_idx);
    w_elem = '0;
    for (int i = 0; i < MM_ELEMS; i++) begin
      if (w_pos.elem == 4'(i)) begin
        w_elem = r_c[i*RES_W +: RES_W];
      end
    end
    w_wide              = '0;
    w_wide[RES_W-1:0]   = w_elem;
    out_data            = 8'h00;
    if (r_valid) begin
      case (w_pos.sel)
        2'd0:    out_data = w_wide[7:0];
        2'd1:    out_data = w_wide[15:8];
        default: out_data = w_wide[23:16];
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/mm_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mm_seq_ctrl
// Description : Byte-stream sequencer for the 3x3 matrix_mult engine. Loads
//               A (9 bytes) then B (9 bytes) row-major, pulses the engine
//               through its enable/done handshake, captures C and streams it
//               out as 27 result bytes.
// Ports       : clk, reset (async, active-low)
//               in_valid/in_data/in_ready    - operand byte stream
//               out_valid/out_data/out_last/out_ready - result byte stream
//               mm_enable/mm_a/mm_b/mm_c/mm_done - engine interface
//               busy - high unless idle in LOAD with nothing loaded
//               err  - sticky engine timeout flag
// Config      : MM_SEQ_TIMEOUT_EN - when defined, RUN aborts after
//               DONE_TIMEOUT cycles without mm_done, sets err and drains
//               27 zero bytes. Undefined: RUN waits forever, err is 0.
// Revision    : 1.0 - initial release
// ============================================================================
module mm_seq_ctrl
  import mm_pkg::*;
#(
  parameter int ELEM_W       = 8,
  parameter int RES_W        = 18,
  parameter int DONE_TIMEOUT = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [ELEM_W-1:0]          in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [7:0]                 out_data,
  output logic                       out_last,
  input  logic                       out_ready,
  output logic                       mm_enable,
  output logic [MM_ELEMS*ELEM_W-1:0] mm_a,
  output logic [MM_ELEMS*ELEM_W-1:0] mm_b,
  input  logic [MM_ELEMS*RES_W-1:0]  mm_c,
  input  logic                       mm_done,
  output logic                       busy,
  output logic                       err
);

  if (RES_W > 24) begin : g_res_w_check
    $error("mm_seq_ctrl: RES_W must fit in three result bytes");
  end
  if (DONE_TIMEOUT < 1) begin : g_timeout_check
    $error("mm_seq_ctrl: DONE_TIMEOUT must be at least 1");
  end

  localparam logic [4:0] c_LAST_LOAD = 5'(MM_LOAD_BYTES - 1);

  mm_seq_state_t              r_state;
  mm_seq_state_t              w_state_next;
  logic [4:0]                 r_ld_cnt;
  logic [MM_ELEMS*ELEM_W-1:0] r_a;
  logic [MM_ELEMS*ELEM_W-1:0] r_b;
  logic                       r_mm_enable;

  logic w_in_fire;
  logic w_capture;
  logic w_timeout;
  logic w_frame_done;

  assign in_ready  = (r_state == LOAD);
  assign w_in_fire = in_valid & in_ready;
  assign mm_enable = r_mm_enable;
  assign mm_a      = r_a;
  assign mm_b      = r_b;
  assign busy      = (r_state != LOAD) || (r_ld_cnt != 5'd0);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= LOAD;
      r_mm_enable <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      // Registered enable: rises with entry to RUN, drops as C is captured.
      r_mm_enable <= (w_state_next == RUN);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    case (r_state)
      LOAD: begin
        if (w_in_fire && (r_ld_cnt == c_LAST_LOAD)) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        // A real result wins over a coincident timeout.
        if (mm_done || w_timeout) begin
          w_capture    = 1'b1;
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (w_frame_done) begin
          w_state_next = LOAD;
        end
      end
      default: w_state_next = LOAD;
    endcase
  end

  // ------------------------------------------------------- operand load
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ld_cnt <= '0;
      r_a      <= '0;
      r_b      <= '0;
    end else if (w_in_fire) begin
      for (int i = 0; i < MM_ELEMS; i++) begin
        if (r_ld_cnt == 5'(i)) begin
          r_a[i*ELEM_W +: ELEM_W] <= in_data;
        end
        if (r_ld_cnt == 5'(i + MM_ELEMS)) begin
          r_b[i*ELEM_W +: ELEM_W] <= in_data;
        end
      end
      r_ld_cnt <= (r_ld_cnt == c_LAST_LOAD) ? 5'd0 : r_ld_cnt + 5'd1;
    end
  end

  // ------------------------------------------------ engine done timeout
`ifdef MM_SEQ_TIMEOUT_EN
  localparam int                 c_WAIT_W    = $clog2(DONE_TIMEOUT + 1);
  localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(DONE_TIMEOUT - 1);

  logic [c_WAIT_W-1:0] r_wait_cnt;
  logic                r_err;

  // Counts RUN cycles already spent; fires on the DONE_TIMEOUT-th one.
  assign w_timeout = (r_state == RUN) && (r_wait_cnt == c_WAIT_LAST);
  assign err       = r_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      if ((r_state == RUN) && (w_state_next == RUN)) begin
        r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
      end else begin
        r_wait_cnt <= '0;
      end
      if (w_timeout && !mm_done) begin
        r_err <= 1'b1;
      end else if (w_in_fire) begin
        r_err <= 1'b0;
      end
    end
  end
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  // ------------------------------------------------- result serializer
  mm_result_serializer #(
    .RES_W (RES_W)
  ) u_serializer (
    .clk        (clk),
    .reset      (reset),
    .capture    (w_capture),
    .zero_fill  (w_timeout & ~mm_done),
    .c_in       (mm_c),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .frame_done (w_frame_done)
  );

endmodule
`default_nettype wire
